// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU responding to the Control Start/DoneALU handshake: add/sub, branch compare,
// and an optional shift-add multiplier built only when ALU_MUL_EN is defined.
`timescale 1ns/1ps
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       ALU_Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             DoneALU,
    output logic             Busy,
    output logic             BranchTaken,
    output logic             Overflow,
    output logic             Error
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] sum, diff;
    logic             ovf_add, ovf_sub;
    logic             is_mul_op;

    assign is_mul_op = (ALU_Op[2:1] == 2'b11);

`ifdef ALU_MUL_EN
    localparam bit MUL_BUILT = 1'b1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [WIDTH:0]     acc;
    logic [CW-1:0]      cnt;
    logic               mul_last;

    // Right-shifting product: low half starts as the multiplier and is consumed LSB first.
    always_comb begin
        acc      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
        prod_nxt = {acc, prod[WIDTH-1:1]};
    end

    assign mul_last = (cnt == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod <= '0;
            cnt  <= '0;
        end else if (state == IDLE && Start && is_mul_op) begin
            prod <= {{WIDTH{1'b0}}, B};
            cnt  <= '0;
        end else if (state == MUL) begin
            prod <= prod_nxt;
            cnt  <= cnt + CW'(1);
        end
    end
`else
    localparam bit MUL_BUILT = 1'b0;
`endif

    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        ovf_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        ovf_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Start) state_nxt = (MUL_BUILT && is_mul_op) ? MUL : EXEC;
            EXEC: state_nxt = DONE;
`ifdef ALU_MUL_EN
            MUL:  state_nxt = mul_last ? DONE : MUL;
`else
            MUL:  state_nxt = IDLE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy    = (state != IDLE);
    assign DoneALU = (state == DONE);

    // Operands latch only in IDLE, so a Start while busy can never disturb them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            Result      <= '0;
            BranchTaken <= 1'b0;
            Overflow    <= 1'b0;
            Error       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    op_q <= ALU_Op;
                    a_q  <= A;
                    b_q  <= B;
                end
                EXEC: begin
                    Error <= 1'b0;
                    case (op_q)
                        3'b000, 3'b010: begin
                            Result      <= sum;
                            Overflow    <= ovf_add;
                            BranchTaken <= 1'b0;
                        end
                        3'b001, 3'b011: begin
                            Result      <= diff;
                            Overflow    <= ovf_sub;
                            BranchTaken <= 1'b0;
                        end
                        3'b100: begin
                            Result      <= diff;
                            Overflow    <= 1'b0;
                            BranchTaken <= (a_q == b_q);
                        end
                        3'b101: begin
                            Result      <= diff;
                            Overflow    <= 1'b0;
                            BranchTaken <= (a_q != b_q);
                        end
                        default: begin
                            // Only reachable for 11X when no multiplier is built.
                            Result      <= '0;
                            Overflow    <= 1'b0;
                            BranchTaken <= 1'b0;
                            Error       <= ~MUL_BUILT;
                        end
                    endcase
                end
                MUL: begin
`ifdef ALU_MUL_EN
                    if (mul_last) begin
                        Result      <= op_q[0] ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
                        Overflow    <= 1'b0;
                        BranchTaken <= 1'b0;
                        Error       <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed spec vectors, randomized ops against an
// arithmetic reference model, busy-Start rejection, back-to-back issue and mid-op reset.
`timescale 1ns/1ps
module tb_alu_exec_unit;

    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MULB = 1'b1;
`else
    localparam bit MULB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         Start = 1'b0;
    logic [2:0]   ALU_Op = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Result;
    logic         DoneALU, Busy, BranchTaken, Overflow, Error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .Start(Start), .ALU_Op(ALU_Op), .A(A), .B(B),
        .Result(Result), .DoneALU(DoneALU), .Busy(Busy), .BranchTaken(BranchTaken),
        .Overflow(Overflow), .Error(Error)
    );

    // Reference: plain integer arithmetic on unsigned / two's-complement interpretations.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic bt, output logic ov, output logic er);
        longint m, ua, ub, sa, sb, s, p;
        m  = longint'(1) << W;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= m/2) ? ua - m : ua;
        sb = (ub >= m/2) ? ub - m : ub;
        r = '0; bt = 1'b0; ov = 1'b0; er = 1'b0;
        case (op)
            3'd0, 3'd2: begin
                s  = sa + sb;
                r  = W'((ua + ub) % m);
                ov = (s >= m/2) || (s < -(m/2));
            end
            3'd1, 3'd3: begin
                s  = sa - sb;
                r  = W'((ua - ub + m) % m);
                ov = (s >= m/2) || (s < -(m/2));
            end
            3'd4, 3'd5: begin
                r  = W'((ua - ub + m) % m);
                bt = (op == 3'd4) ? (ua == ub) : (ua != ub);
            end
            default: begin
                p = ua * ub;
                if (MULB) r = W'(op[0] ? p / m : p % m);
                else      er = 1'b1;
            end
        endcase
    endfunction

    // Rising edges from the one that samples Start to the one after which DoneALU is seen.
    function automatic int exp_lat(input logic [2:0] op);
        return (MULB && op[2:1] == 2'b11) ? W + 1 : 2;
    endfunction

    // Issue one op and observe it for a bounded window; optionally keep Start high with junk
    // operands through the whole busy period including the DONE cycle.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke, output int lat, output int nd, output logic [W-1:0] r,
                          output logic bt, output logic ov, output logic er);
        int el;
        el = exp_lat(op);
        @(negedge clk);
        Start = 1'b1; ALU_Op = op; A = a; B = b;
        lat = -1; nd = 0; r = 'x; bt = 1'bx; ov = 1'bx; er = 1'bx;
        for (int c = 1; c <= W + 6; c++) begin
            @(negedge clk);
            if (DoneALU) begin
                nd++;
                if (lat < 0) begin
                    lat = c; r = Result; bt = BranchTaken; ov = Overflow; er = Error;
                end
            end
            Start  = poke && (c <= el);
            A      = W'($urandom);
            B      = W'($urandom);
            ALU_Op = 3'($urandom);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({Result, DoneALU, Busy, BranchTaken, Overflow, Error} !== '0)
            $display("FAIL reset_outputs: got res=%h done=%b busy=%b bt=%b ov=%b err=%b want all 0",
                     Result, DoneALU, Busy, BranchTaken, Overflow, Error);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", Busy);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, r;
        logic         bt, ov, er;
    } vec_t;

    task automatic test_directed;
        vec_t tbl[9];
        int lat, nd;
        logic [W-1:0] r;
        logic bt, ov, er;
        tbl = '{
            '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0},
            '{3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0},
            '{3'd3, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0},
            '{3'd4, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0},
            '{3'd5, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{3'd2, 16'h0010, 16'hFFF0, 16'h0000, 1'b0, 1'b0, 1'b0},
            '{3'd6, 16'd300,  16'd300,  MULB ? 16'h5F90 : 16'h0000, 1'b0, 1'b0, !MULB},
            '{3'd7, 16'd300,  16'd300,  MULB ? 16'h0001 : 16'h0000, 1'b0, 1'b0, !MULB},
            '{3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0}
        };
        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, lat, nd, r, bt, ov, er);
            checks += 5;
            if (r !== tbl[i].r)
                $display("FAIL dir%0d_result: got %h want %h", i, r, tbl[i].r);
            if ({bt, ov, er} !== {tbl[i].bt, tbl[i].ov, tbl[i].er})
                $display("FAIL dir%0d_flags: got bt/ov/err=%b%b%b want %b%b%b", i, bt, ov, er,
                         tbl[i].bt, tbl[i].ov, tbl[i].er);
            if (lat != exp_lat(tbl[i].op))
                $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(tbl[i].op));
            if (nd != 1)
                $display("FAIL dir%0d_done_pulses: got %0d want 1", i, nd);
            if (Result !== tbl[i].r)
                $display("FAIL dir%0d_hold: got %h want %h", i, Result, tbl[i].r);
            errors += (r !== tbl[i].r) + ({bt, ov, er} !== {tbl[i].bt, tbl[i].ov, tbl[i].er})
                    + (lat != exp_lat(tbl[i].op)) + (nd != 1) + (Result !== tbl[i].r);
        end
    endtask

    task automatic test_random;
        int lat, nd;
        logic [2:0] op;
        logic [W-1:0] a, b, r, er_r;
        logic bt, ov, er, e_bt, e_ov, e_er;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            model(op, a, b, er_r, e_bt, e_ov, e_er);
            run_op(op, a, b, 1'b0, lat, nd, r, bt, ov, er);
            checks++;
            if (r !== er_r || {bt, ov, er} !== {e_bt, e_ov, e_er} || lat != exp_lat(op) || nd != 1) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got res=%h bt/ov/err=%b%b%b lat=%0d done=%0d want res=%h bt/ov/err=%b%b%b lat=%0d done=1",
                         i, op, a, b, r, bt, ov, er, lat, nd, er_r, e_bt, e_ov, e_er, exp_lat(op));
            end
        end
    endtask

    task automatic test_start_while_busy;
        int lat, nd;
        logic [2:0] op;
        logic [W-1:0] a, b, r, e_r;
        logic bt, ov, er, e_bt, e_ov, e_er;
        op = MULB ? 3'd6 : 3'd0;
        a  = MULB ? 16'd300 : 16'h1111;
        b  = MULB ? 16'd300 : 16'h2222;
        model(op, a, b, e_r, e_bt, e_ov, e_er);
        run_op(op, a, b, 1'b1, lat, nd, r, bt, ov, er);
        checks += 3;
        if (r !== e_r) begin
            errors++; $display("FAIL busy_start_result: got %h want %h", r, e_r);
        end
        if (nd != 1) begin
            errors++; $display("FAIL busy_start_done_pulses: got %0d want 1", nd);
        end
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL busy_start_idle_after: got busy=%b want 0", Busy);
        end
    endtask

    task automatic test_back_to_back;
        int t[$];
        logic [W-1:0] rs[$];
        @(negedge clk);
        Start = 1'b1; ALU_Op = 3'd0; A = 16'd2; B = 16'd3;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (DoneALU) begin t.push_back(c); rs.push_back(Result); end
            Start = (c == 3);
            ALU_Op = 3'd1; A = 16'd10; B = 16'd4;
        end
        Start = 1'b0;
        checks++;
        if (t.size() != 2 || t[0] != 2 || t[1] != 5 || rs[0] !== 16'd5 || rs[1] !== 16'd6) begin
            errors++;
            $display("FAIL back_to_back: got %0d dones first@%0d=%h second@%0d=%h want 2 dones @2=0005 @5=0006",
                     t.size(), (t.size() > 0) ? t[0] : -1, (rs.size() > 0) ? rs[0] : 16'hxxxx,
                     (t.size() > 1) ? t[1] : -1, (rs.size() > 1) ? rs[1] : 16'hxxxx);
        end
    endtask

    task automatic test_reset_mid;
        int stray, lat, nd;
        logic [W-1:0] r;
        logic bt, ov, er;
        @(negedge clk);
        Start = 1'b1; ALU_Op = MULB ? 3'd6 : 3'd0; A = MULB ? 16'd300 : 16'h0101; B = MULB ? 16'd300 : 16'h0202;
        @(negedge clk);
        Start = 1'b0;
        if (MULB) repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({Result, DoneALU, Busy, BranchTaken, Overflow, Error} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got res=%h done=%b busy=%b bt=%b ov=%b err=%b want all 0",
                     Result, DoneALU, Busy, BranchTaken, Overflow, Error);
        end
        stray = 0;
        repeat (2) begin @(negedge clk); stray += DoneALU; end
        reset = 1'b1;
        repeat (W + 4) begin @(negedge clk); stray += DoneALU; end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL midreset_stray_done: got %0d pulses want 0", stray);
        end
        run_op(3'd0, 16'd2, 16'd3, 1'b0, lat, nd, r, bt, ov, er);
        checks++;
        if (r !== 16'h0005 || lat != 2 || nd != 1) begin
            errors++;
            $display("FAIL midreset_next_add: got res=%h lat=%0d done=%0d want 0005 lat=2 done=1", r, lat, nd);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
